// File: rtl/conv3x3_window_mac.sv
// Stride-1 3x3 convolution over the line-buffer window bus with int8 weights, 32-bit bias and int8 requantisation.
// Optional macro CONV3X3_RELU_EN clamps negative results to zero before saturation.
module conv3x3_window_mac #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4,
  parameter int SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stream_valid,
  input  logic [8:0][7:0] ifmap_3x3,
  input  logic            wgt_wr_en,
  input  logic [3:0]      wgt_wr_addr,
  input  logic [7:0]      wgt_wr_data,
  input  logic            bias_wr_en,
  input  logic [31:0]     bias_wr_data,
  output logic            busy,
  output logic            out_valid,
  output logic [7:0]      out_data,
  output logic            out_last,
  output logic            frame_err
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [8:0][7:0]    wgt;
  logic [31:0]        bias;

  logic               pend, pend_last;
  logic               v0, l0, v1, l1, v2, l2, v3, l3;
  logic [8:0][7:0]    win;
  logic signed [16:0] prod   [9];
  logic signed [16:0] prod_c [9];
  logic signed [18:0] rsum   [3];
  logic signed [18:0] rsum_c [3];
  logic signed [31:0] acc, acc_c, shifted;
  logic [7:0]         sat;

  logic in_frame, gap, tag, tag_last;

  assign in_frame = (col != '0) || (row != '0);
  assign gap      = !stream_valid && in_frame;
  assign tag      = stream_valid && (row >= ROW_TWO) && (col >= COL_TWO);
  assign tag_last = (row == ROW_LAST) && (col == COL_LAST);

  // Pixel position tracking, coefficient storage and the pipeline valid/last tags.
  // pend tags the pixel just accepted; its window appears on the bus one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      wgt       <= '0;
      bias      <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      v0 <= 1'b0; l0 <= 1'b0;
      v1 <= 1'b0; l1 <= 1'b0;
      v2 <= 1'b0; l2 <= 1'b0;
      v3 <= 1'b0; l3 <= 1'b0;
    end else begin
      if (!busy) begin
        if (wgt_wr_en && (wgt_wr_addr < 4'd9)) wgt[wgt_wr_addr] <= wgt_wr_data;
        if (bias_wr_en) bias <= bias_wr_data;
      end
      if (gap) begin
        col       <= '0;
        row       <= '0;
        frame_err <= 1'b1;
        busy      <= 1'b0;
        pend      <= 1'b0;
        pend_last <= 1'b0;
        v0 <= 1'b0; l0 <= 1'b0;
        v1 <= 1'b0; l1 <= 1'b0;
        v2 <= 1'b0; l2 <= 1'b0;
        v3 <= 1'b0; l3 <= 1'b0;
      end else begin
        if (stream_valid) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        pend      <= tag;
        pend_last <= tag && tag_last;
        v0 <= pend; l0 <= pend_last;
        v1 <= v0;   l1 <= l0;
        v2 <= v1;   l2 <= l1;
        v3 <= v2;   l3 <= l2;
        busy <= stream_valid || in_frame || pend || v0 || v1 || v2 || v3;
      end
    end
  end

  // Datapath registers carry no reset; only their valid tags matter.
  always_ff @(posedge clk) begin
    win  <= ifmap_3x3;
    prod <= prod_c;
    rsum <= rsum_c;
    acc  <= acc_c;
  end

  // Pixels are unsigned, so they are zero-extended before the signed multiply.
  always_comb begin
    for (int k = 0; k < 9; k++)
      prod_c[k] = $signed({9'd0, win[k]}) * $signed({{9{wgt[k][7]}}, wgt[k]});
    for (int r = 0; r < 3; r++)
      rsum_c[r] = {{2{prod[3*r][16]}}, prod[3*r]}
                + {{2{prod[3*r+1][16]}}, prod[3*r+1]}
                + {{2{prod[3*r+2][16]}}, prod[3*r+2]};
    acc_c = {{13{rsum[0][18]}}, rsum[0]}
          + {{13{rsum[1][18]}}, rsum[1]}
          + {{13{rsum[2][18]}}, rsum[2]}
          + bias;
  end

  always_comb begin
    shifted = acc >>> SHIFT;
`ifdef CONV3X3_RELU_EN
    if (shifted < 0) shifted = '0;
`endif
    if (shifted > 32'sd127)       sat = 8'h7f;
    else if (shifted < -32'sd128) sat = 8'h80;
    else                          sat = shifted[7:0];
  end

  // A gap also kills the result that would otherwise be emitted on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (gap) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= v3;
      out_last  <= v3 && l3;
      if (v3) out_data <= sat;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Randomised bench for conv3x3_window_mac: a line-buffer model drives the window bus and a
// frame-level convolution model predicts results for SHIFT=0 and SHIFT=4 instances.
module tb_conv3x3_window_mac;

  localparam int W = 4;
  localparam int H = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            stream_valid;
  logic [8:0][7:0] ifmap_3x3;
  logic            wgt_wr_en;
  logic [3:0]      wgt_wr_addr;
  logic [7:0]      wgt_wr_data;
  logic            bias_wr_en;
  logic [31:0]     bias_wr_data;
  logic            busy_a, out_valid_a, out_last_a, frame_err_a;
  logic [7:0]      out_data_a;
  logic            busy_b, out_valid_b, out_last_b, frame_err_b;
  logic [7:0]      out_data_b;

  always #5 clk = ~clk;

  conv3x3_window_mac #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .stream_valid(stream_valid), .ifmap_3x3(ifmap_3x3),
    .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data),
    .busy(busy_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_last(out_last_a), .frame_err(frame_err_a)
  );

  conv3x3_window_mac #(.IMG_W(W), .IMG_H(H), .SHIFT(4)) dut_b (
    .clk(clk), .rst(rst), .stream_valid(stream_valid), .ifmap_3x3(ifmap_3x3),
    .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data),
    .busy(busy_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_last(out_last_b), .frame_err(frame_err_b)
  );

  typedef struct {
    int due;
    int acc;
    bit last;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] hist[$];
  int         img [H][W];
  int         wm [9];
  int         bm;
  int         cnt;
  int         cyc;
  bit         exp_busy, exp_err, last_prev;
  int         hold_a, hold_b;
  int         errors, checks;

  function automatic int requant(int a, int sh);
    int r;
    r = a >>> sh;
`ifdef CONV3X3_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic int convAt(int r, int c);
    int s;
    s = bm;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        s += img[r-2+kr][c-2+kc] * wm[kr*3+kc];
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: update the model from the inputs sampled at this edge, compare, then present the next window.
  task automatic stepCycle();
    bit         sv_s, rst_s, wen_s, ben_s;
    logic [3:0] waddr_s;
    logic [7:0] wdata_s;
    logic [31:0] bdata_s;
    bit         ev, el;
    int         n, idx, r, c;
    sv_s = stream_valid; rst_s = rst; wen_s = wgt_wr_en; ben_s = bias_wr_en;
    waddr_s = wgt_wr_addr; wdata_s = wgt_wr_data; bdata_s = bias_wr_data;
    @(posedge clk);
    cyc++;
    ev = 0; el = 0;
    if (rst_s) begin
      sbq.delete();
      for (int k = 0; k < 9; k++) wm[k] = 0;
      bm = 0; cnt = 0; exp_busy = 0; exp_err = 0; last_prev = 0;
      hold_a = 0; hold_b = 0;
    end else begin
      if (!exp_busy) begin
        if (wen_s && waddr_s < 9) wm[waddr_s] = int'($signed(wdata_s));
        if (ben_s) bm = int'($signed(bdata_s));
      end
      if (sv_s) begin
        r = cnt / W; c = cnt % W;
        hist.push_back(img[r][c][7:0]);
        while (hist.size() > 3*W) void'(hist.pop_front());
        if (r >= 2 && c >= 2) sbq.push_back('{cyc + 5, convAt(r, c), (r == H-1) && (c == W-1)});
        cnt = (cnt + 1) % (W*H);
        exp_busy = 1;
      end else if (cnt != 0) begin
        exp_err = 1; cnt = 0; sbq.delete(); exp_busy = 0;
      end else if (last_prev && sbq.size() == 0) begin
        exp_busy = 0;
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        ev = 1; el = sbq[0].last;
        hold_a = requant(sbq[0].acc, 0);
        hold_b = requant(sbq[0].acc, 4);
        void'(sbq.pop_front());
      end
      last_prev = el;
    end
    #1;
    checkOutput("out_valid", {31'd0, out_valid_a}, {31'd0, ev});
    checkOutput("out_last", {31'd0, out_last_a}, {31'd0, el});
    checkOutput("out_data", $signed(out_data_a), hold_a);
    checkOutput("s4_valid", {31'd0, out_valid_b}, {31'd0, ev});
    checkOutput("s4_last", {31'd0, out_last_b}, {31'd0, el});
    checkOutput("s4_data", $signed(out_data_b), hold_b);
    checkOutput("busy", {31'd0, busy_a}, {31'd0, exp_busy});
    checkOutput("frame_err", {31'd0, frame_err_a}, {31'd0, exp_err});
    if (sv_s && !rst_s) begin
      n = hist.size();
      for (int k = 0; k < 9; k++) begin
        idx = n - 1 - ((2 - k/3)*W + (2 - k%3));
        ifmap_3x3[k] = (idx >= 0) ? hist[idx] : 8'd0;
      end
    end else begin
      for (int k = 0; k < 9; k++) ifmap_3x3[k] = 8'($urandom);
    end
    wgt_wr_en = 0; bias_wr_en = 0;
  endtask

  task automatic idle(input int n);
    stream_valid = 0;
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Streams one frame; stops early with a gap or a reset at the given pixel index (-1 = none).
  task automatic applyStimulus(input int gap_at, input int rst_at, input bit try_wr);
    for (int p = 0; p < W*H; p++) begin
      if (p == gap_at) begin
        stream_valid = 0;
        stepCycle();
        return;
      end
      if (p == rst_at) begin
        rst = 1; stream_valid = 1;
        stepCycle();
        rst = 0; stream_valid = 0;
        return;
      end
      stream_valid = 1;
      if (try_wr) begin
        wgt_wr_en = 1; wgt_wr_addr = 4'(p % 9); wgt_wr_data = 8'($urandom);
        bias_wr_en = 1; bias_wr_data = $urandom;
      end
      stepCycle();
    end
    stream_valid = 0;
  endtask

  task automatic loadUniform(input int w, input int b);
    for (int k = 0; k < 9; k++) begin
      wgt_wr_en = 1; wgt_wr_addr = 4'(k); wgt_wr_data = 8'(w);
      if (k == 0) begin bias_wr_en = 1; bias_wr_data = 32'(b); end
      stepCycle();
    end
    wgt_wr_en = 1; wgt_wr_addr = 4'd12; wgt_wr_data = 8'($urandom);
    stepCycle();
  endtask

  task automatic loadRandom();
    for (int k = 0; k < 9; k++) begin
      wgt_wr_en = 1; wgt_wr_addr = 4'(k); wgt_wr_data = 8'($urandom);
      if (k == 4) begin bias_wr_en = 1; bias_wr_data = 32'($urandom_range(0, 20000)) - 32'd10000; end
      stepCycle();
    end
  endtask

  task automatic fillConst(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fillRandom();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    rst = 1; stream_valid = 0; ifmap_3x3 = '0;
    wgt_wr_en = 0; wgt_wr_addr = 0; wgt_wr_data = 0; bias_wr_en = 0; bias_wr_data = 0;
    fillConst(0);
    stepCycle();
    stepCycle();
    rst = 0;

    loadUniform(1, 0);    fillConst(1);   applyStimulus(-1, -1, 0); idle(8);
    loadUniform(127, 0);  fillConst(255); applyStimulus(-1, -1, 0); idle(8);
    loadUniform(-1, 0);                   applyStimulus(-1, -1, 0); idle(8);
    loadUniform(16, 0);   fillConst(1);   applyStimulus(-1, -1, 0); idle(8);
    loadUniform(0, -200); fillRandom();   applyStimulus(-1, -1, 0); idle(8);

    loadRandom(); fillRandom(); applyStimulus(7, -1, 0); idle(3);
    fillRandom(); applyStimulus(-1, -1, 0); idle(8);

    loadRandom(); fillRandom(); applyStimulus(-1, -1, 1); idle(8);

    fillRandom(); applyStimulus(-1, -1, 0);
    fillRandom(); applyStimulus(-1, -1, 0); idle(8);

    for (int i = 0; i < 6; i++) begin
      loadRandom();
      fillRandom(); applyStimulus(-1, -1, 0);
      fillRandom(); applyStimulus(-1, -1, 0);
      idle(int'($urandom_range(0, 8)));
    end
    idle(8);

    fillRandom(); applyStimulus(-1, 12, 0); idle(8);
    loadUniform(1, 0); fillConst(1); applyStimulus(-1, -1, 0); idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
